median_filter_stream: RTL and testbench
=======================================

# median_filter_stream

Streaming 3x3 neighbourhood filter for the image pipeline. Consumes one pixel per accepted beat in raster order, holds two lines in internal buffers, and emits one filtered pixel per interior window through a fixed-latency pipelined compare network. It replaces whole-row-per-clock filtering with a pixel-serial block that is parametrised in image size and pixel width, tolerates input gaps, marks frame and line boundaries, and selects median, min, max or bypass per frame.

## Interface
- IMG_W, 100, pixels per line; must be >= 3
- IMG_H, 100, lines per frame; must be >= 3
- PIX_W, 8, bits per pixel
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_pix is valid this cycle; no backpressure, gaps allowed
- in_pix  in  PIX_W  input pixel, raster order
- in_sof  in  1  qualifies in_valid; marks pixel (0,0) of a frame
- mode  in  2  0 median, 1 min, 2 max, 3 bypass (window centre); sampled only with in_sof
- out_valid  out  1  out_pix valid; one-cycle strobe per output pixel
- out_pix  out  PIX_W  filtered pixel
- out_sof  out  1  with out_valid: first output of a frame (window centre (1,1))
- out_eol  out  1  with out_valid: last output of a line (centre column IMG_W-2)
- frame_done  out  1  with out_valid: last output of a frame (centre (IMG_H-2, IMG_W-2))

## Operation
- Output size is (IMG_H-2) x (IMG_W-2). Border pixels are cropped, and no padding is applied.
- FSM states:
  - IDLE: beats without in_sof are ignored.
  - ACTIVE: in_valid && in_sof moves IDLE to ACTIVE, sets (row,col) = (0,0) for that pixel, and latches mode.
- Counters:
  - Each accepted beat advances col. At IMG_W-1, col wraps to 0 and row increments.
  - Acceptance of (IMG_H-1, IMG_W-1) returns the FSM to IDLE.
  - Counter widths are $clog2(IMG_W) and $clog2(IMG_H).
- Line buffers:
  - Two buffers of IMG_W x PIX_W hold rows r-1 and r-2.
  - Indexing is by col, with read and write on the same beat.
  - A 3x3 window register shifts one column per accepted beat only.
- Window launch:
  - An accepted beat at (r,c) with r >= 2 and c >= 2 completes the window centred at (r-1, c-1).
  - That window is launched into the compute pipeline with its valid, sof, eol and last tags.
  - Beats with r < 2 or c < 2 launch nothing.
- Compute:
  - The pipeline is a 4-stage registered network and advances every cycle. Empty slots carry valid = 0.
  - Median is the exact 5th-ranked of the 9 values.
  - Min and max are over all 9 values.
  - Bypass returns the centre value.
  - Comparisons are unsigned PIX_W. No arithmetic widening is needed.
- Mode is held per frame. Changes to mode without in_sof have no effect.
- in_sof while ACTIVE:
  - The current frame is abandoned and counters restart at (0,0) with the new mode.
  - Windows already launched still emerge unchanged.
  - The abandoned frame never asserts frame_done.
- rst:
  - FSM goes to IDLE, counters clear, and all pipeline valid bits clear.
  - In-flight results are discarded and never appear.
  - Line-buffer contents are don't-care, because rows 0 and 1 are rewritten before use.

## Timing
- Reset values: out_valid, out_sof, out_eol and frame_done are 0, out_pix is 0, and the FSM is IDLE.
- Latency: a window is completed by the beat sampled at edge N. Its result is registered at edge N+4, so out_valid is high in the cycle following edge N+4.
- Latency is identical in all modes, bypass included.
- Throughput: up to one output per cycle. Outputs occur only for beats that launched a window, so output gaps mirror input gaps.
- Output order equals raster order of window centres.
- out_sof, out_eol and frame_done are 0 whenever out_valid is 0.
- With IMG_W = 3, every output has out_eol = 1.
- With IMG_H = IMG_W = 3, the single output has out_sof, out_eol and frame_done all set to 1.
- Beat (0,0) with in_sof and the last beat of the previous frame may be adjacent cycles. No idle cycle is required between frames.
- A gapless frame's final output appears 4 cycles after its last beat.

## Test plan
- 4x4 frame, all pixels 0x55, mode 0, gapless:
  - Exactly 4 outputs of 0x55.
  - out_sof on output 1, out_eol on outputs 2 and 4, frame_done on output 4.
  - First out_valid comes 4 cycles after beat (2,2).
- 5x5 frame, all pixels 0x40 except (2,2) = 0xFF:
  - Mode 0: nine outputs, all 0x40.
  - Same frame in mode 3: output 5 = 0xFF and the others = 0x40.
- 6x6 ramp with pixel(r,c) = 6r+c:
  - Mode 1: output for centre (r,c) = 6(r-1)+(c-1).
  - Mode 2: output = 6(r+1)+(c+1).
  - Mode 0: output = 6r+c.
  - Run with IMG_W = IMG_H = 6 and PIX_W = 8.
- Random frame sent twice, once gapless and once with random in_valid gaps (mode 0):
  - Both runs give identical out_pix/out_sof/out_eol/frame_done sequences that match the software median model.
  - Beats without in_sof sent before the first frame produce no output.
- in_sof mid-frame and reset mid-frame:
  - Case A: new in_sof at row 3 of 5x5, mode switching 0 -> 2. Already-launched windows emerge with mode-0 results. The aborted frame has no frame_done, and the new frame produces 9 mode-2 outputs.
  - Case B: rst asserted for 1 cycle mid-frame. No out_valid appears until 4 cycles after beat (2,2) of the next in_sof frame.

Source files
------------

// File: rtl/median_filter_stream.sv
// Pixel-serial 3x3 window filter: two line buffers feed a shifting window, and a
// 4-stage compare network produces median, min, max or the centre pixel.
module median_filter_stream #(
    parameter int IMG_W = 100,
    parameter int IMG_H = 100,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sof,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_sof,
    output logic             out_eol,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    typedef struct packed {
        logic       v;
        logic       sof;
        logic       eol;
        logic       last;
        logic [1:0] mode;
    } tag_t;

    function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [PIX_W-1:0] min3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [PIX_W-1:0] max3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Handshake: in_valid is a one-way strobe with no ready. A beat is consumed when
    // in_valid is high and either in_sof is set or a frame is ACTIVE; otherwise dropped.
    logic [0:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    frame_mode;

    logic          accept;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic [1:0]    beat_mode;

    always_comb begin
        accept    = in_valid && (in_sof || (state == ST_ACTIVE));
        pos_col   = in_sof ? '0 : col;
        pos_row   = in_sof ? '0 : row;
        beat_mode = in_sof ? mode : frame_mode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            frame_mode <= '0;
        end else if (accept) begin
            frame_mode <= beat_mode;
            if (pos_col == COL_LAST) begin
                col <= '0;
                if (pos_row == ROW_LAST) begin
                    row   <= '0;
                    state <= ST_IDLE;
                end else begin
                    row   <= pos_row + 1'b1;
                    state <= ST_ACTIVE;
                end
            end else begin
                col   <= pos_col + 1'b1;
                row   <= pos_row;
                state <= ST_ACTIVE;
            end
        end
    end

    // lb1 holds row r-1, lb2 row r-2; one read-then-write per accepted beat.
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] lb2_rd;

    assign lb1_rd = lb1[pos_col];
    assign lb2_rd = lb2[pos_col];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[pos_col] <= in_pix;
            lb2[pos_col] <= lb1_rd;
        end
    end

    // win[row][col]: row 0 = oldest line, col 2 = newest column.
    logic [2:0][2:0][PIX_W-1:0] win;

    always_ff @(posedge clk) begin
        if (accept) begin
            win[0] <= {lb2_rd, win[0][2:1]};
            win[1] <= {lb1_rd, win[1][2:1]};
            win[2] <= {in_pix, win[2][2:1]};
        end
    end

    tag_t t0, t1, t2, t3;

    always_ff @(posedge clk) begin
        if (rst) begin
            t0 <= '0;
            t1 <= '0;
            t2 <= '0;
            t3 <= '0;
        end else begin
            t0.v    <= accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
            t0.sof  <= (pos_row == RW'(2)) && (pos_col == CW'(2));
            t0.eol  <= pos_col == COL_LAST;
            t0.last <= (pos_row == ROW_LAST) && (pos_col == COL_LAST);
            t0.mode <= beat_mode;
            t1      <= t0;
            t2      <= t1;
            t3      <= t2;
        end
    end

    // Exact median of 9: median of (max of row mins, median of row medians, min of row maxes).
    logic [2:0][PIX_W-1:0] s1_lo, s1_mid, s1_hi;
    logic [PIX_W-1:0]      s1_ctr;
    logic [PIX_W-1:0]      s2_lomax, s2_midmed, s2_himin, s2_min, s2_max, s2_ctr;
    logic [PIX_W-1:0]      s3_med, s3_min, s3_max, s3_ctr;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            s1_lo[i]  <= min3(win[i][0], win[i][1], win[i][2]);
            s1_mid[i] <= med3(win[i][0], win[i][1], win[i][2]);
            s1_hi[i]  <= max3(win[i][0], win[i][1], win[i][2]);
        end
        s1_ctr <= win[1][1];

        s2_lomax  <= max3(s1_lo[0], s1_lo[1], s1_lo[2]);
        s2_midmed <= med3(s1_mid[0], s1_mid[1], s1_mid[2]);
        s2_himin  <= min3(s1_hi[0], s1_hi[1], s1_hi[2]);
        s2_min    <= min3(s1_lo[0], s1_lo[1], s1_lo[2]);
        s2_max    <= max3(s1_hi[0], s1_hi[1], s1_hi[2]);
        s2_ctr    <= s1_ctr;

        s3_med <= med3(s2_lomax, s2_midmed, s2_himin);
        s3_min <= s2_min;
        s3_max <= s2_max;
        s3_ctr <= s2_ctr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pix    <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= t3.v;
            out_sof    <= t3.v && t3.sof;
            out_eol    <= t3.v && t3.eol;
            frame_done <= t3.v && t3.last;
            if (t3.v) begin
                case (t3.mode)
                    2'd0:    out_pix <= s3_med;
                    2'd1:    out_pix <= s3_min;
                    2'd2:    out_pix <= s3_max;
                    default: out_pix <= s3_ctr;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_median_filter_stream.sv
// Bench for median_filter_stream: four square instances (3..6) share one stimulus bus,
// outputs are checked against a sort-based window model plus hand-derived table values.
module tb_median_filter_stream;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_pix;
    logic [1:0] mode;
    int         sel;
    int         cyc = 0;

    logic [3:0]      o_valid, o_sof, o_eol, o_done;
    logic [3:0][7:0] o_pix;

    always #5 tb_clk = ~tb_clk;
    always @(posedge tb_clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        median_filter_stream #(.IMG_W(k + 3), .IMG_H(k + 3), .PIX_W(8)) u_dut (
            .clk        (tb_clk),
            .rst        (rst),
            .in_valid   (in_valid && (sel == k)),
            .in_pix     (in_pix),
            .in_sof     (in_sof),
            .mode       (mode),
            .out_valid  (o_valid[k]),
            .out_pix    (o_pix[k]),
            .out_sof    (o_sof[k]),
            .out_eol    (o_eol[k]),
            .frame_done (o_done[k])
        );
    end

    typedef struct {
        int          k;
        logic [10:0] val;
        int          cyc;
    } obs_t;

    obs_t        got_q[$];
    logic [10:0] exp_q[$];
    logic [10:0] run_q[$];
    logic [10:0] prev_q[$];
    int          img[6][6];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          stray_cnt = 0;

    // Monitor: {frame_done, out_eol, out_sof, out_pix} per output, tagged with instance and edge.
    always @(negedge tb_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (o_valid[k])
                got_q.push_back('{k, {o_done[k], o_eol[k], o_sof[k], o_pix[k]}, cyc});
            else if (o_sof[k] || o_eol[k] || o_done[k])
                stray_cnt++;
        end
    end

    task automatic beat(input logic v, input logic [7:0] p, input logic s, input logic [1:0] m);
        in_valid = v;
        in_pix   = p;
        in_sof   = s;
        mode     = m;
        @(posedge tb_clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 8'h00, 1'b0, 2'd0);
    endtask

    task automatic fill_img(input int pat, input int fill, input int spike);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                case (pat)
                    0:       img[r][c] = fill;
                    1:       img[r][c] = (r == 2 && c == 2) ? spike : fill;
                    2:       img[r][c] = 6 * r + c;
                    default: img[r][c] = int'($urandom_range(255));
                endcase
    endtask

    // Reference: every window centre whose bottom-right beat was sent, in raster order.
    task automatic build_exp(input int k, input int md, input int nbeats);
        int n;
        int v;
        n = k + 3;
        for (int cr = 1; cr <= n - 2; cr++)
            for (int cc = 1; cc <= n - 2; cc++)
                if ((cr + 1) * n + (cc + 1) < nbeats) begin
                    int w[$];
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            w.push_back(img[cr + dr][cc + dc]);
                    w.sort();
                    case (md)
                        0:       v = w[4];
                        1:       v = w[0];
                        2:       v = w[8];
                        default: v = img[cr][cc];
                    endcase
                    exp_q.push_back({(cr == n - 2) && (cc == n - 2), cc == n - 2,
                                     (cr == 1) && (cc == 1), 8'(v)});
                end
    endtask

    // Sends the first nbeats pixels of img; random gaps, random mode/sof on non-frame-start beats.
    task automatic send_frame(input int k, input int md, input int nbeats, input int gap_pct,
                              output int e22, output int elast);
        int n;
        int r;
        int c;
        n     = k + 3;
        e22   = -100;
        elast = -100;
        for (int i = 0; i < nbeats; i++) begin
            r = i / n;
            c = i % n;
            for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++)
                beat(1'b0, 8'($urandom_range(255)), 1'($urandom_range(1)), 2'($urandom_range(3)));
            beat(1'b1, 8'(img[r][c]), i == 0, (i == 0) ? 2'(md) : 2'($urandom_range(3)));
            if (r == 2 && c == 2) e22 = cyc;
            elast = cyc;
        end
    endtask

    task automatic check_run(input string name, input int k, output int first_cyc, output int last_cyc);
        int n;
        idle(8);
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s count: got %0d outputs, expected %0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (got_q[i].k != k || got_q[i].val !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s out[%0d]: got inst %0d {done,eol,sof,pix}=%h, expected inst %0d %h",
                         name, i, got_q[i].k, got_q[i].val, k, exp_q[i]);
            end
        end
        first_cyc = (got_q.size() > 0) ? got_q[0].cyc : -1;
        last_cyc  = (got_q.size() > 0) ? got_q[got_q.size() - 1].cyc : -1;
        run_q.delete();
        foreach (got_q[i]) run_q.push_back(got_q[i].val);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        string name;
        int    k;
        int    md;
        int    pat;
        int    fill;
        int    spike;
        int    gap;
        int    exp_cnt;
        int    idx;
        int    exp_val;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int e22, elast, fc, lc;

        tbl[0] = '{"flat4_med",    1, 0, 0, 'h55, 'h55, 0,  4,  3, 'h55};
        tbl[1] = '{"spike5_med",   2, 0, 1, 'h40, 'hff, 0,  9,  4, 'h40};
        tbl[2] = '{"spike5_byp",   2, 3, 1, 'h40, 'hff, 0,  9,  4, 'hff};
        tbl[3] = '{"spike5_byp0",  2, 3, 1, 'h40, 'hff, 0,  9,  0, 'h40};
        tbl[4] = '{"ramp6_min",    3, 1, 2, 0,    0,    0,  16, 5, 7};
        tbl[5] = '{"ramp6_max",    3, 2, 2, 0,    0,    0,  16, 5, 21};
        tbl[6] = '{"ramp6_med",    3, 0, 2, 0,    0,    0,  16, 5, 14};
        tbl[7] = '{"ramp6_medgap", 3, 0, 2, 0,    0,    30, 16, 15, 28};

        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_pix = 8'h00;
        mode = 2'd0;
        sel = 0;
        repeat (3) @(posedge tb_clk);
        @(negedge tb_clk);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (o_valid[k] !== 1'b0 || o_pix[k] !== 8'h00 || o_sof[k] !== 1'b0 ||
                o_eol[k] !== 1'b0 || o_done[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_inst%0d: valid=%b pix=%h sof=%b eol=%b done=%b, expected all 0",
                         k, o_valid[k], o_pix[k], o_sof[k], o_eol[k], o_done[k]);
            end
        end
        @(posedge tb_clk);
        #1;
        rst = 1'b0;

        // Random 6x6 median frame: stray beats first, then gapless, then same image with gaps.
        sel = 3;
        for (int i = 0; i < 5; i++) beat(1'b1, 8'($urandom_range(255)), 1'b0, 2'($urandom_range(3)));
        fill_img(3, 0, 0);
        build_exp(3, 0, 36);
        send_frame(3, 0, 36, 0, e22, elast);
        check_run("rand_gapless", 3, fc, lc);
        check_int("rand_gapless_last_latency", lc - elast, 4);
        prev_q = run_q;
        build_exp(3, 0, 36);
        send_frame(3, 0, 36, 40, e22, elast);
        check_run("rand_gaps", 3, fc, lc);
        n_tests++;
        if (run_q != prev_q) begin
            n_fail++;
            $display("FAIL rand_repeat: gapped run size %0d differs from gapless run size %0d",
                     run_q.size(), prev_q.size());
        end

        for (int t = 0; t < 8; t++) begin
            sel = tbl[t].k;
            fill_img(tbl[t].pat, tbl[t].fill, tbl[t].spike);
            build_exp(tbl[t].k, tbl[t].md, (tbl[t].k + 3) * (tbl[t].k + 3));
            send_frame(tbl[t].k, tbl[t].md, (tbl[t].k + 3) * (tbl[t].k + 3), tbl[t].gap, e22, elast);
            check_run(tbl[t].name, tbl[t].k, fc, lc);
            check_int({tbl[t].name, "_count"}, run_q.size(), tbl[t].exp_cnt);
            check_int({tbl[t].name, "_sample"},
                      (run_q.size() > tbl[t].idx) ? int'(run_q[tbl[t].idx][7:0]) : -1, tbl[t].exp_val);
            check_int({tbl[t].name, "_first_latency"}, fc - e22, 4);
            check_int({tbl[t].name, "_last_latency"}, lc - elast, 4);
        end

        // 3x3: two back-to-back frames, each a single output carrying sof, eol and done.
        sel = 0;
        fill_img(3, 0, 0);
        build_exp(0, 0, 9);
        send_frame(0, 0, 9, 0, e22, elast);
        fill_img(3, 0, 0);
        build_exp(0, 1, 9);
        send_frame(0, 1, 9, 0, e22, elast);
        check_run("b2b_3x3", 0, fc, lc);

        // Case A: new in_sof at row 3 of a 5x5 frame, mode 0 -> 2.
        sel = 2;
        fill_img(3, 0, 0);
        build_exp(2, 0, 17);
        send_frame(2, 0, 17, 0, e22, elast);
        fill_img(3, 0, 0);
        build_exp(2, 2, 25);
        send_frame(2, 2, 25, 0, e22, elast);
        check_run("abort_sof", 2, fc, lc);
        check_int("abort_sof_count", run_q.size(), 12);

        // Case B: reset while windows are in flight; stray beats after reset must be ignored.
        sel = 1;
        fill_img(3, 0, 0);
        send_frame(1, 0, 15, 0, e22, elast);
        rst = 1'b1;
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        idle(6);
        for (int i = 0; i < 3; i++) beat(1'b1, 8'($urandom_range(255)), 1'b0, 2'($urandom_range(3)));
        fill_img(3, 0, 0);
        build_exp(1, 1, 16);
        send_frame(1, 1, 16, 20, e22, elast);
        check_run("reset_mid", 1, fc, lc);
        check_int("reset_mid_first_latency", fc - e22, 4);

        check_int("flags_without_valid", stray_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
